// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state type, the register-specifier default and the control output presets.
package pipe_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pcWe;
    logic pcSel;
    logic ifidWe;
    logic idexWe;
    logic exmemWe;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic err;
  } ctrl_t;

  // While reset is held every stage is cleared and nothing is written.
  localparam ctrl_t CTRL_RESET = '{pcWe: 1'b0, pcSel: 1'b0, ifidWe: 1'b0, idexWe: 1'b0,
                                   exmemWe: 1'b0, ifidFlush: 1'b1, idexFlush: 1'b1,
                                   exmemFlush: 1'b1, err: 1'b0};
  localparam ctrl_t CTRL_DEFAULT = '{pcWe: 1'b1, pcSel: 1'b0, ifidWe: 1'b1, idexWe: 1'b1,
                                     exmemWe: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b0,
                                     exmemFlush: 1'b0, err: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pcWe: 1'b0, pcSel: 1'b0, ifidWe: 1'b0, idexWe: 1'b0,
                                    exmemWe: 1'b0, ifidFlush: 1'b0, idexFlush: 1'b0,
                                    exmemFlush: 1'b0, err: 1'b0};
  localparam ctrl_t CTRL_REDIR = '{pcWe: 1'b1, pcSel: 1'b1, ifidWe: 1'b1, idexWe: 1'b1,
                                   exmemWe: 1'b1, ifidFlush: 1'b1, idexFlush: 1'b1,
                                   exmemFlush: 1'b1, err: 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{pcWe: 1'b0, pcSel: 1'b0, ifidWe: 1'b0, idexWe: 1'b1,
                                    exmemWe: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b1,
                                    exmemFlush: 1'b0, err: 1'b0};
  localparam ctrl_t CTRL_ERR = '{pcWe: 1'b0, pcSel: 1'b0, ifidWe: 1'b0, idexWe: 1'b0,
                                 exmemWe: 1'b0, ifidFlush: 1'b0, idexFlush: 1'b0,
                                 exmemFlush: 1'b0, err: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the pipeline registers and stage controls back to them.
// HAZ_PERF_CNT_EN adds the read-only performance counters.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
);

  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_uses_rt;
  logic              idex_memread;
  logic [REG_AW-1:0] idex_rt;
  logic              exmem_branch_taken;
  logic              exmem_jump;
  logic              exmem_memreq;
  logic              dmem_ready;

  logic pc_we;
  logic pc_sel;
  logic ifid_we;
  logic idex_we;
  logic exmem_we;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu;
  logic [31:0] perf_redir;
  logic [31:0] perf_mwait;
`endif

  modport master (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           exmem_branch_taken, exmem_jump, exmem_memreq, dmem_ready,
    output pc_we, pc_sel, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush, err
`ifdef HAZ_PERF_CNT_EN
    , output perf_lu, perf_redir, perf_mwait
`endif
  );

  modport slave (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           exmem_branch_taken, exmem_jump, exmem_memreq, dmem_ready,
    input  pc_we, pc_sel, ifid_we, idex_we, exmem_we,
           ifid_flush, idex_flush, exmem_flush, err
`ifdef HAZ_PERF_CNT_EN
    , input perf_lu, perf_redir, perf_mwait
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational load-use comparator: flags an ID instruction reading the register an EX load writes.
// Register 0 is hard-wired zero and never creates a dependency.
module hazard_cmp #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              usesRt,
  input  logic              memRead,
  input  logic [REG_AW-1:0] loadRt,
  output logic              lu
);

  assign lu = memRead && (loadRt != '0) &&
              ((loadRt == rs) || (usesRt && (loadRt == rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: zero-latency stall/flush/redirect controls; memory stalls
// freeze every stage and time out into a sticky ERR. HAZ_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.master bus
);

  hz_state_t         state;
  hz_state_t         nextState;
  logic [WAIT_W-1:0] wcnt;
  logic [WAIT_W-1:0] nextWcnt;
  ctrl_t             ctrl;

  logic lu;
  logic memStall;
  logic redirect;
  logic active;
  logic stallFire;
  logic redirFire;
  logic bubbleFire;

  hazard_cmp #(.REG_AW(REG_AW)) uCmp (
    .rs     (bus.ifid_rs),
    .rt     (bus.ifid_rt),
    .usesRt (bus.ifid_uses_rt),
    .memRead(bus.idex_memread),
    .loadRt (bus.idex_rt),
    .lu     (lu)
  );

  assign memStall = bus.exmem_memreq && !bus.dmem_ready;
  assign redirect = bus.exmem_branch_taken || bus.exmem_jump;

  // Priority memstall > redirect > load-use; ERR overrides all of them.
  assign active     = (state != ERR);
  assign stallFire  = active && memStall;
  assign redirFire  = active && !memStall && redirect;
  assign bubbleFire = active && !memStall && !redirect && lu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= nextState;
      wcnt  <= nextWcnt;
    end
  end

  always_comb begin
    ctrl      = CTRL_DEFAULT;
    nextState = state;
    nextWcnt  = wcnt;
    case (state)
      RUN, MWAIT: begin
        if (stallFire) begin
          ctrl      = CTRL_FREEZE;
          nextState = (wcnt == WAIT_W'(MAX_WAIT)) ? ERR : MWAIT;
          nextWcnt  = (wcnt == '1) ? wcnt : wcnt + 1'b1;
        end else begin
          nextState = RUN;
          nextWcnt  = '0;
          if (redirFire) begin
            ctrl = CTRL_REDIR;
          end else if (bubbleFire) begin
            ctrl = CTRL_BUBBLE;
          end
        end
      end
      default: begin
        ctrl = CTRL_ERR;
      end
    endcase
    // Reset forces the pipeline clear even before the first clock edge.
    if (!rst) begin
      ctrl = CTRL_RESET;
    end
  end

  assign bus.pc_we       = ctrl.pcWe;
  assign bus.pc_sel      = ctrl.pcSel;
  assign bus.ifid_we     = ctrl.ifidWe;
  assign bus.idex_we     = ctrl.idexWe;
  assign bus.exmem_we    = ctrl.exmemWe;
  assign bus.ifid_flush  = ctrl.ifidFlush;
  assign bus.idex_flush  = ctrl.idexFlush;
  assign bus.exmem_flush = ctrl.exmemFlush;
  assign bus.err         = ctrl.err;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perfLu;
  logic [31:0] perfRedir;
  logic [31:0] perfMwait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfLu    <= '0;
      perfRedir <= '0;
      perfMwait <= '0;
    end else begin
      if (bubbleFire) perfLu    <= perfLu + 32'd1;
      if (redirFire)  perfRedir <= perfRedir + 32'd1;
      if (stallFire)  perfMwait <= perfMwait + 32'd1;
    end
  end

  assign bus.perf_lu    = perfLu;
  assign bus.perf_redir = perfRedir;
  assign bus.perf_mwait = perfMwait;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed checks of pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 15;
  localparam int WAIT_W   = 4;

  // Output vector order: pc_we pc_sel ifid_we idex_we exmem_we ifid_flush idex_flush exmem_flush err
  localparam logic [8:0] O_RST    = 9'b0_0_000_111_0;
  localparam logic [8:0] O_DEF    = 9'b1_0_111_000_0;
  localparam logic [8:0] O_FREEZE = 9'b0_0_000_000_0;
  localparam logic [8:0] O_REDIR  = 9'b1_1_111_111_0;
  localparam logic [8:0] O_BUBBLE = 9'b0_0_011_010_0;
  localparam logic [8:0] O_ERR    = 9'b0_0_000_000_1;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

  pipe_hazard_ctrl #(
    .REG_AW  (REG_AW),
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: sticky error flag, run length of consecutive stalls, event counts.
  bit modelErr = 1'b0;
  int stallRun = 0;
  int mLu = 0;
  int mRedir = 0;
  int mWait = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.pc_we, bus.pc_sel, bus.ifid_we, bus.idex_we, bus.exmem_we,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.err};
  endfunction

  function automatic bit refLoadUse();
    if (!bus.idex_memread || bus.idex_rt == 0) return 1'b0;
    return (bus.idex_rt == bus.ifid_rs) || (bus.ifid_uses_rt && bus.idex_rt == bus.ifid_rt);
  endfunction

  function automatic logic [8:0] refOuts();
    if (!rst) return O_RST;
    if (modelErr) return O_ERR;
    if (bus.exmem_memreq && !bus.dmem_ready) return O_FREEZE;
    if (bus.exmem_branch_taken || bus.exmem_jump) return O_REDIR;
    if (refLoadUse()) return O_BUBBLE;
    return O_DEF;
  endfunction

  task automatic modelEdge();
    if (!rst) begin
      modelErr = 1'b0;
      stallRun = 0;
      mLu = 0;
      mRedir = 0;
      mWait = 0;
    end else if (!modelErr) begin
      if (bus.exmem_memreq && !bus.dmem_ready) begin
        stallRun++;
        mWait++;
        if (stallRun > MAX_WAIT) modelErr = 1'b1;
      end else begin
        stallRun = 0;
        if (bus.exmem_branch_taken || bus.exmem_jump) mRedir++;
        else if (refLoadUse()) mLu++;
      end
    end
  endtask

  task automatic drive(input int rs, input int rt, input bit usesRt, input bit memRead,
                       input int ldRt, input bit br, input bit jmp, input bit req, input bit rdy);
    bus.ifid_rs            = REG_AW'(rs);
    bus.ifid_rt            = REG_AW'(rt);
    bus.ifid_uses_rt       = usesRt;
    bus.idex_memread       = memRead;
    bus.idex_rt            = REG_AW'(ldRt);
    bus.exmem_branch_taken = br;
    bus.exmem_jump         = jmp;
    bus.exmem_memreq       = req;
    bus.dmem_ready         = rdy;
  endtask

  task automatic idle();
    drive(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Inputs are driven at the falling edge; outputs are sampled 1 ns later.
  task automatic cycle(input string tag, input logic [8:0] want, input bit useWant);
    #1;
    checkVal(tag, 32'(outs()), 32'(refOuts()));
    if (useWant) checkVal({tag, "_const"}, 32'(outs()), 32'(want));
`ifdef HAZ_PERF_CNT_EN
    checkVal("perf_lu", bus.perf_lu, mLu);
    checkVal("perf_redir", bus.perf_redir, mRedir);
    checkVal("perf_mwait", bus.perf_mwait, mWait);
`endif
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic resetPulse();
    rst = 1'b0;
    idle();
    cycle("reset", O_RST, 1'b1);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    @(negedge clk);
    resetPulse();
    cycle("post_reset", O_DEF, 1'b1);

    // Load-use on rs, then defaults; no hazard through r0.
    drive(5, 9, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("lu_rs", O_BUBBLE, 1'b1);
    idle();
    cycle("lu_clear", O_DEF, 1'b1);
    drive(0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("lu_r0", O_DEF, 1'b1);
    drive(3, 7, 1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("lu_rt", O_BUBBLE, 1'b1);
    drive(3, 7, 1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("lu_rt_unused", O_DEF, 1'b1);

    // Taken branch and jump each redirect for exactly one cycle.
    drive(1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("branch", O_REDIR, 1'b1);
    idle();
    cycle("branch_after", O_DEF, 1'b1);
    drive(5, 2, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle("jump_and_lu", O_REDIR, 1'b1);

    // Three-cycle memory wait, then resume; stall beats a concurrent redirect.
    drive(1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("mwait1", O_FREEZE, 1'b1);
    drive(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("mwait2", O_FREEZE, 1'b1);
    cycle("mwait3", O_FREEZE, 1'b1);
    drive(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("mwait_done", O_DEF, 1'b1);
    idle();
    cycle("mwait_run", O_DEF, 1'b1);

    // Timeout: 16 stalled edges reach ERR, which is sticky until reset.
    drive(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MAX_WAIT + 1; i++) cycle("timeout_stall", O_FREEZE, 1'b1);
    cycle("err_entered", O_ERR, 1'b1);
    drive(5, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("err_sticky", O_ERR, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    checkVal("err_async_reset", 32'(outs()), 32'(O_RST));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    rst = 1'b1;
    idle();
    cycle("after_err_reset", O_DEF, 1'b1);

    // Stall counter clears on any non-stall cycle, so 15+15 stalls never reach ERR.
    for (int r = 0; r < 2; r++) begin
      drive(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < MAX_WAIT; i++) cycle("near_timeout", O_FREEZE, 1'b1);
      idle();
      cycle("near_timeout_ok", O_DEF, 1'b1);
    end

`ifdef HAZ_PERF_CNT_EN
    resetPulse();
    for (int i = 0; i < 2; i++) begin
      drive(4, 1, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("perf_bubble", O_BUBBLE, 1'b1);
      idle();
      cycle("perf_idle", O_DEF, 1'b1);
    end
    drive(1, 2, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("perf_redir_cyc", O_REDIR, 1'b1);
    drive(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("perf_wait", O_FREEZE, 1'b1);
    idle();
    #1;
    checkVal("perf_lu_total", bus.perf_lu, 32'd2);
    checkVal("perf_redir_total", bus.perf_redir, 32'd1);
    checkVal("perf_mwait_total", bus.perf_mwait, 32'd3);
    @(negedge clk);
`endif

    // Random traffic with small register numbers so dependencies are frequent.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        resetPulse();
      end else begin
        drive($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 7),
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        cycle("random", O_DEF, 1'b0);
      end
    end

    // Random run ending with a long stall burst to exercise timeout from random state.
    drive(1, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MAX_WAIT + 4; i++) cycle("random_burst", O_FREEZE, 1'b0);
    checkVal("burst_err", 32'(bus.err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
